result_display: RTL and testbench
=================================

RESULT_DISPLAY -- requirements
Module: result_display

Interface
- REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
- REQ-002 The block SHALL have the following ports:
  - clock  input  1  system clock; all state on rising edge.
  - reset  input  1  synchronous, active-low reset.
  - Halt  input  1  processor halt flag; high means the result is final.
  - dataOut  input  8  processor result (GCD), unsigned binary.
  - IR  input  3  processor instruction register, for status display.
  - HEX0  output  7  units digit, active-low segments, bit order gfedcba.
  - HEX1  output  7  tens digit, same encoding.
  - HEX2  output  7  hundreds digit, same encoding.
  - HEX3  output  7  IR value as digit 0-7, same encoding.
  - busy  output  1  high while a conversion is in progress.
  - valid  output  1  high while HEX0-HEX2 hold a converted result.

Function
- REQ-003 The FSM SHALL have three states, transitioning as follows:
  - IDLE -> CONVERT on a Halt rising edge (Halt=1 and previous registered Halt=0).
  - CONVERT -> SHOW after exactly 8 shift iterations.
  - SHOW -> IDLE when Halt=0.
- REQ-004 On the IDLE->CONVERT edge, the block SHALL latch dataOut into an 8-bit shift register and clear a 12-bit BCD accumulator.
- REQ-005 The conversion SHALL be sequential double-dabble, one iteration per cycle, with a 3-bit iteration counter:
  - first add 3 to every BCD nibble >= 5;
  - then shift {bcd, bin} left by one.
- REQ-006 Latency: if Halt is first sampled high at edge N, valid SHALL rise at edge N+9 and busy SHALL be high from N+1 through N+8.
- REQ-007 Changes on dataOut after edge N SHALL NOT affect the displayed result.
- REQ-008 The 4-bit digit to segment mapping SHALL be:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- REQ-009 HEX0-HEX2 SHALL be blank in IDLE and CONVERT, and SHALL show the BCD digits in SHOW.
- REQ-010 HEX3 SHALL show IR in all states, registered with a one-cycle delay.
- REQ-011 Output range SHALL be 0-255; the hundreds nibble never exceeds 2.
- REQ-012 Halt falling during CONVERT SHALL NOT abort the conversion: the block completes, enters SHOW, then returns to IDLE on the next cycle.
- REQ-013 Halt falling and rising again while in SHOW SHALL pass through IDLE, so a new rising edge is required before the next conversion.
- REQ-014 Halt held high continuously SHALL trigger exactly one conversion.

Reset
- REQ-015 When reset=0 at a clock edge, the block SHALL clear the following, regardless of state, including mid-CONVERT:
  - state=IDLE, busy=0, valid=0;
  - HEX0-HEX2=1111111, HEX3=1000000;
  - shift register, accumulator, counter and previous-Halt register all cleared.
- REQ-016 A Halt level already high when reset releases SHALL NOT start a conversion, because the previous-Halt register resets to 1.

Configuration
- REQ-017 With macro RESULT_DISPLAY_LZ_BLANK_EN defined, leading zeros in SHOW SHALL be blanked:
  - HEX2 is blank if the hundreds digit is 0;
  - HEX1 is blank if hundreds and tens are both 0;
  - HEX0 always shows its digit.
- REQ-018 Without RESULT_DISPLAY_LZ_BLANK_EN, all three digits SHALL show, including zeros.
- REQ-019 Timing and all other behaviour SHALL be identical with and without the macro.

Structure
- REQ-020 A shared package result_display_pkg SHALL hold:
  - the state typedef (IDLE, CONVERT, SHOW);
  - the segment constants SEG_0 through SEG_9 and SEG_BLANK;
  - RESULT_W=8, BCD_W=12, ITER_MAX=8.
- REQ-021 Digit decoding SHALL be a combinational sub-module seg7_decode (4-bit digit plus blank input in, 7-bit segments out), instantiated four times.

Verification
- REQ-022 dataOut=1, Halt rises at edge N:
  - busy is high for 8 cycles;
  - at N+9, with macro: HEX2/HEX1/HEX0 = blank/blank/1111001;
  - without macro: 1000000/1000000/1111001.
- REQ-023 dataOut=255 -> 0100100/0010010/0010010 (2,5,5) and valid=1.
- REQ-024 dataOut=100 with macro -> 1111001/1000000/1000000; the middle zero is not blanked.
- REQ-025 dataOut=0 with macro -> blank/blank/1000000.
- REQ-026 Reset pulled low at CONVERT iteration 4, then Halt is held high:
  - the block is in IDLE with all HEX0-HEX2 blank;
  - no conversion starts until Halt falls and rises again.
- REQ-027 In SHOW, dataOut changes to 7 while Halt stays high -> display unchanged.
- REQ-028 Halt falls in SHOW -> valid=0 and digits blank on the next cycle; IR=5 gives HEX3=0010010 one cycle later.

Source files
------------

// File: rtl/result_display_pkg.sv
// Shared types and constants for the result display block: FSM state
// encoding, active-low 7-segment patterns (bit order gfedcba) and the
// datapath widths of the binary-to-BCD converter.
package result_display_pkg;

  localparam int RESULT_W = 8;
  localparam int BCD_W    = 12;
  localparam int ITER_MAX = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHOW    = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/result_display_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder. A high blank
// input, or a digit above 9, turns every segment off.
module seg7_decode
  import result_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Table lookup from digit value to segment pattern.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/result_display.sv
// Result display: when the processor halts, the 8-bit result is converted
// to three BCD digits by sequential double-dabble (one iteration per cycle)
// and shown on HEX2..HEX0; HEX3 always shows the instruction register.
// Optional feature macro: RESULT_DISPLAY_LZ_BLANK_EN blanks leading zeros
// of the shown result (units digit is never blanked).
//
// Status outputs: busy and valid are registered levels, no handshake.
// busy is high for the eight cycles following the start of a conversion;
// valid is high while HEX2..HEX0 carry a converted result. Both, and all
// HEX outputs, are registered one cycle behind the FSM state.
module result_display
  import result_display_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                Halt,
  input  logic [RESULT_W-1:0] dataOut,
  input  logic [2:0]          IR,
  output logic [6:0]          HEX0,
  output logic [6:0]          HEX1,
  output logic [6:0]          HEX2,
  output logic [6:0]          HEX3,
  output logic                busy,
  output logic                valid,
  output state_t              fsm_state
);

  localparam logic [2:0] ITER_LAST = 3'(ITER_MAX - 1);

  state_t                       state_q;
  state_t                       state_d;
  logic                         halt_q;
  logic [RESULT_W-1:0]          bin_q;
  logic [BCD_W-1:0]             bcd_q;
  logic [BCD_W-1:0]             bcd_adj;
  logic [2:0]                   cnt_q;
  logic [BCD_W+RESULT_W-1:0]    shifted;
  logic                         start;
  logic                         show;
  logic                         blank2;
  logic                         blank1;
  logic [6:0]                   seg0;
  logic [6:0]                   seg1;
  logic [6:0]                   seg2;
  logic [6:0]                   seg3;

  // Rising edge of Halt; halt_q resets high so a Halt already asserted at
  // reset release is not mistaken for a new edge.
  assign start     = Halt && !halt_q;
  assign show      = (state_q == SHOW);
  assign fsm_state = state_q;

  // FSM state and previous-Halt register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      halt_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      halt_q  <= Halt;
    end
  end

  // Next-state logic; a conversion always runs to completion once started.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONVERT;
      CONVERT: if (cnt_q == ITER_LAST) state_d = SHOW;
      SHOW:    if (!Halt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Double-dabble correction: add 3 to every BCD nibble of 5 or more.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {bcd_adj, bin_q} << 1;

  // Conversion datapath: latch the result on start, then shift 8 times.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (state_q == IDLE && start) begin
      bin_q <= dataOut;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (state_q == CONVERT) begin
      {bcd_q, bin_q} <= shifted;
      cnt_q          <= cnt_q + 3'd1;
    end
  end

`ifdef RESULT_DISPLAY_LZ_BLANK_EN
  assign blank2 = !show || (bcd_q[11:8] == 4'd0);
  assign blank1 = !show || (bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0);
`else
  assign blank2 = !show;
  assign blank1 = !show;
`endif

  seg7_decode u_dec0 (.digit(bcd_q[3:0]),  .blank(!show), .seg(seg0));
  seg7_decode u_dec1 (.digit(bcd_q[7:4]),  .blank(blank1), .seg(seg1));
  seg7_decode u_dec2 (.digit(bcd_q[11:8]), .blank(blank2), .seg(seg2));
  seg7_decode u_dec3 (.digit({1'b0, IR}),  .blank(1'b0),   .seg(seg3));

  // Registered display and status outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      HEX0  <= SEG_BLANK;
      HEX1  <= SEG_BLANK;
      HEX2  <= SEG_BLANK;
      HEX3  <= SEG_0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      HEX0  <= seg0;
      HEX1  <= seg1;
      HEX2  <= seg2;
      HEX3  <= seg3;
      busy  <= (state_q == CONVERT);
      valid <= show;
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Testbench for result_display: randomized conversions checked by a
// scoreboard against a decimal-arithmetic reference model.
module tb_result_display;

  logic       clock;
  logic       reset;
  logic       Halt;
  logic [7:0] dataOut;
  logic [2:0] IR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic       busy, valid;
  result_display_pkg::state_t fsm_state;

  int checks = 0;
  int errors = 0;

  logic [20:0] exp_q[$];
  logic [20:0] cur_exp = '0;
  logic        mon_en  = 1'b0;
  logic        valid_d = 1'b0;
  logic [2:0]  ir_s    = 3'd0;

  localparam logic [6:0] BLANK = 7'b1111111;
  logic [6:0] seg_tab [0:9];

  result_display dut (
    .clock(clock), .reset(reset), .Halt(Halt), .dataOut(dataOut), .IR(IR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .busy(busy), .valid(valid), .fsm_state(fsm_state)
  );

  // Clock and reset-control block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decimal digits from plain division, then segments.
  function automatic logic [20:0] model(input logic [7:0] v);
    int h, t, u;
    logic [6:0] s2, s1, s0;
    h = int'(v) / 100;
    t = (int'(v) / 10) % 10;
    u = int'(v) % 10;
    s2 = seg_tab[h];
    s1 = seg_tab[t];
    s0 = seg_tab[u];
`ifdef RESULT_DISPLAY_LZ_BLANK_EN
    if (h == 0) s2 = BLANK;
    if (h == 0 && t == 0) s1 = BLANK;
`endif
    return {s2, s1, s0};
  endfunction

  // IR as the DUT saw it at the last rising edge (zero under reset).
  always @(posedge clock) ir_s <= !reset ? 3'd0 : IR;

  // Monitor: pops an expected result when valid rises, checks it holds
  // while valid, checks blank digits otherwise, and checks HEX3 each cycle.
  always @(negedge clock) begin
    if (mon_en) begin
      if (valid && !valid_d) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      if (valid) check("digits", {HEX2, HEX1, HEX0}, cur_exp);
      else       check("blank_digits", {HEX2, HEX1, HEX0}, {BLANK, BLANK, BLANK});
      check("hex3", HEX3, seg_tab[ir_s]);
      valid_d = valid;
    end
  end

  // Driver tasks
  task automatic step();
    @(negedge clock);
    IR = 3'($urandom_range(0, 7));
  endtask

  // Start a conversion of v; optionally drop Halt after sample drop_at.
  task automatic convert(input logic [7:0] v, input int drop_at);
    int busy_n;
    int valid_t;
    busy_n  = 0;
    valid_t = 0;
    dataOut = v;
    Halt    = 1'b1;
    exp_q.push_back(model(v));
    for (int s = 1; s <= 20 && valid_t == 0; s++) begin
      step();
      dataOut = 8'($urandom);
      if (busy) busy_n++;
      if (valid) valid_t = s;
      if (s == drop_at) Halt = 1'b0;
    end
    check("busy_cycles", busy_n, 8);
    check("valid_latency", valid_t, 10);
  endtask

  // Convert, hold in SHOW with dataOut wandering, then release Halt.
  task automatic convert_show(input logic [7:0] v);
    int hold;
    convert(v, 0);
    hold = $urandom_range(2, 6);
    for (int i = 0; i < hold; i++) begin
      step();
      dataOut = 8'($urandom);
      check("no_retrigger", busy, 1'b0);
      check("valid_hold", valid, 1'b1);
    end
    Halt = 1'b0;
    step();
    check("valid_after_drop", valid, 1'b1);
    step();
    check("valid_cleared", valid, 1'b0);
  endtask

  // Main stimulus sequence
  initial begin
    reset = 1'b0; Halt = 1'b0; IR = 3'd0; dataOut = 8'd0;
    step();
    step();
    mon_en = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", valid, 1'b0);
    check("rst_hex", {HEX3, HEX2, HEX1, HEX0}, {7'b1000000, BLANK, BLANK, BLANK});
    check("rst_state", fsm_state, result_display_pkg::IDLE);
    reset = 1'b1;
    step();
    step();

    convert_show(8'd1);
    convert_show(8'd255);
    convert_show(8'd100);
    convert_show(8'd0);
    convert_show(8'd10);
    for (int i = 0; i < 24; i++) convert_show(8'($urandom));

    // Halt drops mid-conversion: conversion still completes, one-cycle SHOW.
    convert(8'($urandom), 3);
    step();
    check("short_show_valid", valid, 1'b0);
    step();

    // Reset in the middle of a conversion, Halt held high afterwards.
    Halt    = 1'b1;
    dataOut = 8'($urandom);
    for (int i = 0; i < 4; i++) step();
    reset = 1'b0;
    step();
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", valid, 1'b0);
    check("midrst_state", fsm_state, result_display_pkg::IDLE);
    reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      check("midrst_no_start", {busy, valid}, 2'b00);
    end
    Halt = 1'b0;
    step();
    convert_show(8'd137);

    // Halt already high when reset releases.
    reset = 1'b0;
    Halt  = 1'b1;
    step();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("relhigh_no_start", {busy, valid}, 2'b00);
    end
    Halt = 1'b0;
    step();
    convert_show(8'd42);

    step();
    step();
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
